// File: rtl/clk_divider_bank.sv
// -----------------------------------------------------------------------------
// clk_divider_bank
//   A bank of CHANNELS independent clock dividers. Each divide ratio can be
//   changed at run time through a valid/ready config port. A new ratio is held
//   in a per-channel shadow register and only takes effect at a period
//   boundary, so the divided clocks never glitch.
//
//   Optional feature: define CLKDIV_SYNC_EN to add the `sync` input. It
//   restarts all running channels together, phase aligned, and applies any
//   pending divisors. Without the macro, channels are aligned only by reset.
//
// Ports
//   I_CLK      in   1         system clock, rising edge
//   rst_n      in   1         asynchronous reset, active low
//   cfg_valid  in   1         config write request
//   cfg_ready  out  1         config slot free for cfg_chan (combinational)
//   cfg_chan   in   CHAN_W    target channel (>= CHANNELS: write is dropped)
//   cfg_div    in   WIDTH     new divisor N (0 = stop, 1 behaves as 2)
//   O_CLK      out  CHANNELS  divided clock level, bit c = channel c
//   O_TICK     out  CHANNELS  one-cycle strobe in the first cycle of a period
//   busy       out  CHANNELS  channel has a divisor waiting to be applied
//   sync       in   1         (CLKDIV_SYNC_EN only) restart all channels
// -----------------------------------------------------------------------------
module clk_divider_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                I_CLK,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  output logic [CHANNELS-1:0] O_CLK,
  output logic [CHANNELS-1:0] O_TICK,
  output logic [CHANNELS-1:0] busy
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic                sync
`endif
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
  // Reset parks each channel on the last count of its period so that the
  // first edge after release starts a fresh period on every running channel.
  localparam logic [WIDTH-1:0] RST_CNT = (DEFAULT_DIV > 0) ? WIDTH'(DEFAULT_DIV - 1) : '0;

  logic sync_i;
  logic chan_ok;

`ifdef CLKDIV_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  // Out-of-range channel numbers always look ready and are silently dropped.
  assign chan_ok = (int'(cfg_chan) < CHANNELS);

  always_comb begin
    cfg_ready = 1'b1;
    if (chan_ok) begin
      cfg_ready = ~busy[cfg_chan];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] div_q, div_d;
      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] shadow_q, shadow_d;
      logic             pend_q, pend_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic             wr_hit;
      logic             boundary;
      logic             apply;
      logic [WIDTH-1:0] new_div;
      logic [WIDTH-1:0] eff_div;
      logic [WIDTH-1:0] cnt_inc;

      assign wr_hit = cfg_valid && cfg_ready && chan_ok && (int'(cfg_chan) == gi);

      always_comb begin
        new_div  = (shadow_q == ONE) ? TWO : shadow_q;
        // A stopped channel sits on a boundary every cycle, so a pending
        // divisor is picked up on the very next edge.
        boundary = (div_q == '0) || (cnt_q == (div_q - ONE)) || sync_i;
        apply    = boundary && pend_q;
        eff_div  = apply ? new_div : div_q;
        cnt_inc  = cnt_q + ONE;

        div_d    = eff_div;
        shadow_d = wr_hit ? cfg_div : shadow_q;
        // A write can only be accepted while nothing is pending, so the set
        // and clear of pend never coincide.
        pend_d   = wr_hit ? 1'b1 : (apply ? 1'b0 : pend_q);
        cnt_d    = cnt_q;
        clk_d    = 1'b0;
        tick_d   = 1'b0;

        if (eff_div == '0) begin
          // Stopped: count frozen, outputs parked low.
          cnt_d = cnt_q;
        end else if ((div_q == '0) && !sync_i) begin
          // Waking up from stop: park on end-of-period for one cycle, the
          // following edge starts the first period.
          cnt_d = eff_div - ONE;
        end else if (boundary) begin
          cnt_d  = '0;
          clk_d  = ((eff_div >> 1) != '0);
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          clk_d = (cnt_inc < (div_q >> 1));
        end
      end

      always_ff @(posedge I_CLK or negedge rst_n) begin
        if (!rst_n) begin
          div_q    <= RST_DIV;
          cnt_q    <= RST_CNT;
          shadow_q <= '0;
          pend_q   <= 1'b0;
          clk_q    <= 1'b0;
          tick_q   <= 1'b0;
        end else begin
          div_q    <= div_d;
          cnt_q    <= cnt_d;
          shadow_q <= shadow_d;
          pend_q   <= pend_d;
          clk_q    <= clk_d;
          tick_q   <= tick_d;
        end
      end

      assign O_CLK[gi]  = clk_q;
      assign O_TICK[gi] = tick_q;
      assign busy[gi]   = pend_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_divider_bank.sv
module tb_clk_divider_bank;

  localparam int CH = 5;
  localparam int W  = 16;
  localparam int CW = 3;

  logic          I_CLK = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan = '0;
  logic [W-1:0]  cfg_div = '0;
  logic [CH-1:0] O_CLK;
  logic [CH-1:0] O_TICK;
  logic [CH-1:0] busy;
`ifdef CLKDIV_SYNC_EN
  logic          sync = 1'b0;
`endif

  always #5 I_CLK = ~I_CLK;

  clk_divider_bank #(
    .CHANNELS(CH),
    .WIDTH(W),
    .DEFAULT_DIV(2)
  ) dut (
    .I_CLK(I_CLK),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_div(cfg_div),
    .O_CLK(O_CLK),
    .O_TICK(O_TICK),
    .busy(busy)
`ifdef CLKDIV_SYNC_EN
    ,
    .sync(sync)
`endif
  );

  typedef struct {
    logic [CH-1:0] clk;
    logic [CH-1:0] tick;
    logic [CH-1:0] busy;
  } exp_t;

  typedef struct {
    int            gap;
    logic [CW-1:0] chan;
    logic [W-1:0]  div;
    logic          ready;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[10];
  int   vectors;
  int   miscompares;
  int   edge_no;

  // Reference schedule per channel: period start edge and ratio
  // (ratio 0 = stopped), plus one pending divisor and its apply edge.
  int   m_start[CH];
  int   m_n[CH];
  int   p_edge[CH];
  int   p_n[CH];
  bit   p_valid[CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s after edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 1) ? 2 : d;
  endfunction

  function automatic int pmod(input int a, input int n);
    return ((a % n) + n) % n;
  endfunction

  // Edge on which a divisor transferred on edge t takes effect: the edge
  // after the first boundary state at or after t.
  function automatic int apply_edge(input int c, input int t);
    if (m_n[c] == 0) return t + 1;
    for (int b = t; b <= t + m_n[c]; b++) begin
      if (pmod(b - m_start[c], m_n[c]) == m_n[c] - 1) return b + 1;
    end
    return t + 1;
  endfunction

  task automatic reset_model();
    edge_no = 0;
    for (int c = 0; c < CH; c++) begin
      m_start[c] = 1;
      m_n[c]     = 2;
      p_valid[c] = 1'b0;
      p_edge[c]  = 0;
      p_n[c]     = 0;
    end
  endtask

  task automatic model_step(input int e, input bit xfer, input int ch, input int d, input bit s);
    exp_t ex;
    ex.clk  = '0;
    ex.tick = '0;
    ex.busy = '0;
    for (int c = 0; c < CH; c++) begin
      if (s) begin
        if (p_valid[c]) begin
          m_n[c]     = eff(p_n[c]);
          p_valid[c] = 1'b0;
        end
        if (m_n[c] != 0) m_start[c] = e;
      end else if (p_valid[c] && (e == p_edge[c])) begin
        m_start[c] = (m_n[c] == 0) ? e + 1 : e;
        m_n[c]     = eff(p_n[c]);
        p_valid[c] = 1'b0;
      end
    end
    if (xfer) begin
      p_valid[ch] = 1'b1;
      p_n[ch]     = d;
      p_edge[ch]  = apply_edge(ch, e);
    end
    for (int c = 0; c < CH; c++) begin
      if (m_n[c] != 0 && e >= m_start[c]) begin
        int k;
        k = (e - m_start[c]) % m_n[c];
        ex.clk[c]  = (k < m_n[c] / 2);
        ex.tick[c] = (k == 0);
      end
      ex.busy[c] = p_valid[c];
    end
    sb_q.push_back(ex);
  endtask

  // One clock cycle: drive inputs, check cfg_ready, queue the expectation for
  // the coming edge, then compare the registered outputs after it.
  task automatic run_cycle(input bit v, input logic [CW-1:0] ch, input logic [W-1:0] d,
                           input bit exp_rdy, input bit s);
    exp_t ex;
    cfg_valid = v;
    cfg_chan  = ch;
    cfg_div   = d;
`ifdef CLKDIV_SYNC_EN
    sync = s;
`endif
    #1;
    if (v) check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
    model_step(edge_no + 1, v && exp_rdy && (int'(ch) < CH), int'(ch), int'(d), s);
    @(posedge I_CLK);
    edge_no++;
    @(negedge I_CLK);
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty after edge %0d: got none, expected an entry", edge_no);
    end else begin
      ex = sb_q.pop_front();
      check("O_CLK", 32'(O_CLK), 32'(ex.clk));
      check("O_TICK", 32'(O_TICK), 32'(ex.tick));
      check("busy", 32'(busy), 32'(ex.busy));
    end
    $display("edge %0d: v=%0b ch=%0d div=%0d rdy=%0b O_CLK=%b O_TICK=%b busy=%b",
             edge_no, v, ch, d, cfg_ready, O_CLK, O_TICK, busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_model();

    // gap idle cycles, then one write {chan, div} with the expected cfg_ready
    tbl[0] = '{10, 3'd1, 16'd5, 1'b1};  // edge 11: ch1 N=5, applied at edge 13
    tbl[1] = '{0,  3'd1, 16'd9, 1'b0};  // edge 12: ch1 busy, refused
    tbl[2] = '{0,  3'd1, 16'd9, 1'b0};  // edge 13: still busy in the apply cycle
    tbl[3] = '{0,  3'd1, 16'd3, 1'b1};  // edge 14: accepted, applied at edge 18
    tbl[4] = '{2,  3'd2, 16'd0, 1'b1};  // edge 17: ch2 stop, effective edge 19
    tbl[5] = '{0,  3'd3, 16'd7, 1'b1};  // edge 18: ch3 N=7, applied at edge 19
    tbl[6] = '{3,  3'd2, 16'd1, 1'b1};  // edge 22: ch2 N=1 -> 2, restarts edge 24
    tbl[7] = '{0,  3'd5, 16'd9, 1'b1};  // edge 23: channel out of range, dropped
    tbl[8] = '{0,  3'd0, 16'd4, 1'b1};  // edge 24: ch0 N=4, applied at edge 25
    tbl[9] = '{0,  3'd7, 16'd2, 1'b1};  // edge 25: channel out of range, dropped

    // Asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset_O_CLK", 32'(O_CLK), 32'd0);
    check("reset_O_TICK", 32'(O_TICK), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (2) @(posedge I_CLK);
    @(negedge I_CLK);
    rst_n = 1'b1;
    reset_model();

    for (int i = 0; i < 10; i++) begin
      idle(tbl[i].gap);
      run_cycle(1'b1, tbl[i].chan, tbl[i].div, tbl[i].ready, 1'b0);
    end
    idle(12);

    // Reset mid-period: ch3 runs N=7 and gets a pending N=3
    run_cycle(1'b1, 3'd3, 16'd3, 1'b1, 1'b0);
    check("pre_reset_busy3", 32'(busy[3]), 32'd1);
    check("pre_reset_clk0", 32'(O_CLK[0]), 32'd1);
    cfg_valid = 1'b0;
    cfg_chan  = 3'd3;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_O_CLK", 32'(O_CLK), 32'd0);
    check("midreset_O_TICK", 32'(O_TICK), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge I_CLK);
    @(negedge I_CLK);
    rst_n = 1'b1;
    reset_model();
    idle(2);

`ifdef CLKDIV_SYNC_EN
    run_cycle(1'b1, 3'd0, 16'd4, 1'b1, 1'b0);  // edge 3
    run_cycle(1'b1, 3'd3, 16'd6, 1'b1, 1'b0);  // edge 4
    idle(4);
    run_cycle(1'b0, '0, '0, 1'b1, 1'b1);       // edge 9: sync pulse
    check("sync_tick_coincide", 32'(O_TICK[0] & O_TICK[3]), 32'd1);
    idle(11);                                   // edges 10..20
    run_cycle(1'b0, '0, '0, 1'b1, 1'b0);       // edge 21
    check("sync_tick_12cyc", 32'(O_TICK[0] & O_TICK[3]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b0, '0, '0, 1'b1, 1'b1);     // sync held high
      check("sync_held_tick", 32'(O_TICK), 32'h1f);
    end
    idle(4);
`else
    run_cycle(1'b1, 3'd4, 16'd3, 1'b1, 1'b0);
    idle(10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
